axi_add_bcd7seg: RTL and testbench

//  Parametrised AXI-stream accumulator with decimal display output. Sums a group of up to
//  NUM_COUNT unsigned beats; a group closes early on s_last. Converts the sum to NUM_DIGITS
//  BCD digits with a sequential double-dabble, then presents BCD, 7-segment codes and an

---
 rtl/axi_add_bcd7seg.sv | 202 ++++++++++++++++++++
 tb/tb_axi_add_bcd7seg.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_add_bcd7seg.sv
// rtl/axi_add_bcd7seg.sv - stream accumulator with sequential BCD conversion and 7-segment output
//
// Sums groups of unsigned s_data beats. A group closes on its NUM_COUNT-th beat or on s_last.
// The sum is converted to NUM_DIGITS BCD digits by a double-dabble that shifts once per clock.
// The result is then held on the m_* handshake until it is accepted.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-low reset
//   s_valid/s_ready input beat handshake; s_data unsigned operand; s_last closes the group
//   m_valid/m_ready result handshake, m_valid held until accepted
//   m_bcd           BCD digits, ones in [3:0]
//   m_seg           active-high {g,f,e,d,c,b,a} per digit, ones in [6:0]
//   m_ovf           sum did not fit in NUM_DIGITS digits (digits saturate to 9)
//   m_count         number of beats in the reported group
module axi_add_bcd7seg #(
    parameter int DATA_W     = 8,
    parameter int NUM_COUNT  = 8,
    parameter int NUM_DIGITS = 3,
    parameter int BLANK_LZ   = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_W-1:0]                s_data,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [4*NUM_DIGITS-1:0]          m_bcd,
    output logic [7*NUM_DIGITS-1:0]          m_seg,
    output logic                             m_ovf,
    output logic [$clog2(NUM_COUNT+1)-1:0]   m_count
);

    localparam int SUM_W = DATA_W + $clog2(NUM_COUNT);
    localparam int CNT_W = $clog2(NUM_COUNT + 1);
    localparam int SH_W  = $clog2(SUM_W + 1);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;

    localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Walks from the most significant digit down; while only zeros have been seen the digit
    // is a leading zero. The ones digit always ends the leading run so a zero sum shows "0".
    function automatic logic [SEG_W-1:0] seg_digits(input logic [BCD_W-1:0] bcd_in);
        logic [SEG_W-1:0] res;
        logic [3:0]       d;
        logic             lead;
        res  = '0;
        lead = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            d = bcd_in[4*i +: 4];
            if (d != 4'd0 || i == 0) begin
                lead = 1'b0;
            end
            res[7*i +: 7] = (BLANK_LZ != 0 && lead) ? 7'h00 : seg7(d);
        end
        return res;
    endfunction

    localparam logic [SEG_W-1:0] RESET_SEG = seg_digits({BCD_W{1'b0}});

    typedef enum logic [1:0] {
        S_ACCUM = 2'd0,
        S_CONV  = 2'd1,
        S_OUT   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [SUM_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_cap;
    logic [SUM_W-1:0] bin;
    logic [BCD_W-1:0] bcd;
    logic [SH_W-1:0]  sh_cnt;
    logic             ovf_acc;

    logic [SUM_W-1:0] sum;
    logic             accept;
    logic             close_beat;
    logic             last_shift;
    logic [BCD_W-1:0] bcd_next;
    logic [3:0]       dd_adj;
    logic             dd_carry;
    logic             ovf_next;
    logic [BCD_W-1:0] result_bcd;

    assign sum        = acc + SUM_W'(s_data);
    assign accept     = s_valid & s_ready;
    assign close_beat = s_last || (cnt == CNT_W'(NUM_COUNT - 1));
    assign last_shift = (sh_cnt == SH_W'(1));

    // One double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
    // The bit carried out of the top digit means the value no longer fits; since the value
    // only grows during the conversion, a sticky flag of those carries is the overflow.
    always_comb begin
        bcd_next = '0;
        dd_adj   = '0;
        dd_carry = bin[SUM_W-1];
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dd_adj = bcd[4*i +: 4];
            if (dd_adj >= 4'd5) begin
                dd_adj = dd_adj + 4'd3;
            end
            bcd_next[4*i +: 4] = {dd_adj[2:0], dd_carry};
            dd_carry = dd_adj[3];
        end
        ovf_next   = ovf_acc | dd_carry;
        result_bcd = ovf_next ? ALL_NINES : bcd_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_ACCUM: if (accept && close_beat) state_next = S_CONV;
            S_CONV:  if (last_shift)           state_next = S_OUT;
            S_OUT:   if (m_ready)              state_next = S_ACCUM;
            default:                           state_next = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_bcd   <= '0;
            m_seg   <= RESET_SEG;
            m_ovf   <= 1'b0;
            m_count <= '0;
            acc     <= '0;
            cnt     <= '0;
            cnt_cap <= '0;
            bin     <= '0;
            bcd     <= '0;
            sh_cnt  <= '0;
            ovf_acc <= 1'b0;
        end else begin
            // Handshake flags follow the next state, so s_ready returns only in the cycle
            // after the result is accepted.
            s_ready <= (state_next == S_ACCUM);
            m_valid <= (state_next == S_OUT);
            case (state)
                S_ACCUM: begin
                    if (accept) begin
                        if (close_beat) begin
                            bin     <= sum;
                            bcd     <= '0;
                            sh_cnt  <= SH_W'(SUM_W);
                            ovf_acc <= 1'b0;
                            cnt_cap <= cnt + CNT_W'(1);
                            acc     <= '0;
                            cnt     <= '0;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_CONV: begin
                    bin     <= bin << 1;
                    bcd     <= bcd_next;
                    sh_cnt  <= sh_cnt - SH_W'(1);
                    ovf_acc <= ovf_next;
                    if (last_shift) begin
                        m_bcd   <= result_bcd;
                        m_seg   <= seg_digits(result_bcd);
                        m_ovf   <= ovf_next;
                        m_count <= cnt_cap;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_add_bcd7seg.sv
// tb/tb_axi_add_bcd7seg.sv - self-checking bench for axi_add_bcd7seg with a behavioural model
module tb_axi_add_bcd7seg;

    localparam int NC = 8;
    localparam int SW = 11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b0;

    logic        s_ready_a, m_valid_a, m_ovf_a;
    logic [11:0] m_bcd_a;
    logic [20:0] m_seg_a;
    logic [3:0]  m_count_a;
    logic        s_ready_b, m_valid_b, m_ovf_b;
    logic [11:0] m_bcd_b;
    logic [20:0] m_seg_b;
    logic [3:0]  m_count_b;

    axi_add_bcd7seg #(.DATA_W(8), .NUM_COUNT(NC), .NUM_DIGITS(3), .BLANK_LZ(0)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready), .m_bcd(m_bcd_a),
        .m_seg(m_seg_a), .m_ovf(m_ovf_a), .m_count(m_count_a)
    );

    axi_add_bcd7seg #(.DATA_W(8), .NUM_COUNT(NC), .NUM_DIGITS(3), .BLANK_LZ(1)) dut_b (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready), .m_bcd(m_bcd_b),
        .m_seg(m_seg_b), .m_ovf(m_ovf_b), .m_count(m_count_b)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] digit_seg(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tbl[d];
    endfunction

    function automatic logic [11:0] model_bcd(input int sum);
        if (sum >= 1000) return 12'h999;
        return {4'(sum / 100), 4'((sum / 10) % 10), 4'(sum % 10)};
    endfunction

    function automatic logic [20:0] model_seg(input int sum, input bit blank);
        logic [20:0] r;
        int p;
        bit ovf;
        int d;
        r = '0;
        p = 1;
        ovf = (sum >= 1000);
        for (int i = 0; i < 3; i++) begin
            d = ovf ? 9 : (sum / p) % 10;
            if (blank && !ovf && i > 0 && sum < p) r[7*i +: 7] = 7'h00;
            else r[7*i +: 7] = digit_seg(d);
            p = p * 10;
        end
        return r;
    endfunction

    bit          e_ready = 1'b1;
    bit          e_valid = 1'b0;
    logic [11:0] e_bcd = 12'h000;
    logic [20:0] e_seg_a = {7'h3F, 7'h3F, 7'h3F};
    logic [20:0] e_seg_b = {7'h00, 7'h00, 7'h3F};
    logic        e_ovf = 1'b0;
    logic [3:0]  e_count = 4'd0;
    int grp_sum = 0, grp_cnt = 0, pend_sum = 0, pend_cnt = 0, timer = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_ready = 1'b1; e_valid = 1'b0; e_bcd = 12'h000;
            e_seg_a = model_seg(0, 1'b0); e_seg_b = model_seg(0, 1'b1);
            e_ovf = 1'b0; e_count = 4'd0;
            grp_sum = 0; grp_cnt = 0; pend_sum = 0; pend_cnt = 0; timer = 0;
        end else if (e_ready && s_valid) begin
            grp_sum += int'(s_data);
            grp_cnt++;
            if (grp_cnt == NC || s_last) begin
                pend_sum = grp_sum; pend_cnt = grp_cnt;
                grp_sum = 0; grp_cnt = 0;
                e_ready = 1'b0;
                timer = SW;
            end
        end else if (timer > 0) begin
            timer--;
            if (timer == 0) begin
                e_valid = 1'b1;
                e_bcd = model_bcd(pend_sum);
                e_seg_a = model_seg(pend_sum, 1'b0);
                e_seg_b = model_seg(pend_sum, 1'b1);
                e_ovf = (pend_sum >= 1000);
                e_count = 4'(pend_cnt);
            end
        end else if (e_valid && m_ready) begin
            e_valid = 1'b0;
            e_ready = 1'b1;
        end
    end

    bit run_cmp = 1'b0;

    always @(negedge clk) begin
        if (run_cmp) begin
            check("cmp_s_ready",   32'(s_ready_a), 32'(e_ready));
            check("cmp_m_valid",   32'(m_valid_a), 32'(e_valid));
            check("cmp_m_bcd",     32'(m_bcd_a),   32'(e_bcd));
            check("cmp_m_seg",     32'(m_seg_a),   32'(e_seg_a));
            check("cmp_m_ovf",     32'(m_ovf_a),   32'(e_ovf));
            check("cmp_m_count",   32'(m_count_a), 32'(e_count));
            check("cmp_b_s_ready", 32'(s_ready_b), 32'(e_ready));
            check("cmp_b_m_valid", 32'(m_valid_b), 32'(e_valid));
            check("cmp_b_m_bcd",   32'(m_bcd_b),   32'(e_bcd));
            check("cmp_b_m_seg",   32'(m_seg_b),   32'(e_seg_b));
            check("cmp_b_m_ovf",   32'(m_ovf_b),   32'(e_ovf));
            check("cmp_b_m_count", 32'(m_count_b), 32'(e_count));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] d, input bit last);
        bit ok;
        int n;
        ok = 1'b0;
        n = 0;
        s_valid = 1'b1;
        s_data = d;
        s_last = last;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = s_ready_a;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) check("beat_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_valid_a && n < 200);
        if (!m_valid_a) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
    endtask

    int lat;

    initial begin
        #2 reset = 1'b0;
        run_cmp = 1'b1;
        idle(3);
        check("rst_bcd",   32'(m_bcd_a),   32'h000);
        check("rst_seg",   32'(m_seg_a),   32'({7'h3F, 7'h3F, 7'h3F}));
        check("rst_seg_b", 32'(m_seg_b),   32'({7'h00, 7'h00, 7'h3F}));
        check("rst_valid", 32'(m_valid_a), 32'd0);
        check("rst_ready", 32'(s_ready_a), 32'd1);
        check("rst_count", 32'(m_count_a), 32'd0);
        reset = 1'b1;
        idle(1);

        // eight 7s, closed by count
        for (int i = 0; i < 8; i++) beat(8'd7, 1'b0);
        check("conv_s_ready", 32'(s_ready_a), 32'd0);
        wait_valid(lat);
        check("lat7",    32'(lat),       32'd11);
        check("bcd7",    32'(m_bcd_a),   32'h056);
        check("seg7",    32'(m_seg_a),   32'({7'h3F, 7'h6D, 7'h7D}));
        check("seg7_b",  32'(m_seg_b),   32'({7'h00, 7'h6D, 7'h7D}));
        check("ovf7",    32'(m_ovf_a),   32'd0);
        check("count7",  32'(m_count_a), 32'd8);
        idle(20);
        check("hold_valid", 32'(m_valid_a), 32'd1);
        check("hold_ready", 32'(s_ready_a), 32'd0);
        check("hold_bcd",   32'(m_bcd_a),   32'h056);
        handshake();
        check("hs_ready", 32'(s_ready_a), 32'd1);
        check("hs_valid", 32'(m_valid_a), 32'd0);

        // overflow
        for (int i = 0; i < 8; i++) beat(8'd255, 1'b0);
        wait_valid(lat);
        check("bcd_ovf",   32'(m_bcd_a),   32'h999);
        check("seg_ovf",   32'(m_seg_a),   32'({7'h6F, 7'h6F, 7'h6F}));
        check("seg_ovf_b", 32'(m_seg_b),   32'({7'h6F, 7'h6F, 7'h6F}));
        check("ovf_flag",  32'(m_ovf_a),   32'd1);
        handshake();

        // early close on s_last, m_ready already high before the result exists
        m_ready = 1'b1;
        beat(8'd100, 1'b0);
        beat(8'd200, 1'b0);
        beat(8'd255, 1'b1);
        check("last_conv_ready", 32'(s_ready_a), 32'd0);
        wait_valid(lat);
        check("lat_last",   32'(lat),       32'd11);
        check("bcd_555",    32'(m_bcd_a),   32'h555);
        check("count_3",    32'(m_count_a), 32'd3);
        idle(1);
        m_ready = 1'b0;
        check("auto_hs_valid", 32'(m_valid_a), 32'd0);

        // same group of 7s with random gaps
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, 3));
            beat(8'd7, 1'b0);
        end
        wait_valid(lat);
        check("gap_bcd",   32'(m_bcd_a),   32'h056);
        check("gap_count", 32'(m_count_a), 32'd8);
        handshake();

        // s_last on the final allowed beat, then a single-beat zero group
        for (int i = 1; i <= 8; i++) beat(8'(i), i == 8);
        wait_valid(lat);
        check("bcd_36",   32'(m_bcd_a),   32'h036);
        check("count_36", 32'(m_count_a), 32'd8);
        handshake();
        beat(8'd0, 1'b1);
        wait_valid(lat);
        check("bcd_zero",    32'(m_bcd_a),   32'h000);
        check("seg_zero_b",  32'(m_seg_b),   32'({7'h00, 7'h00, 7'h3F}));
        check("count_one",   32'(m_count_a), 32'd1);
        handshake();

        // reset during conversion drops the pending group
        beat(8'd9, 1'b0);
        beat(8'd9, 1'b1);
        idle(3);
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(m_valid_a), 32'd0);
        check("midrst_ready", 32'(s_ready_a), 32'd1);
        idle(2);
        reset = 1'b1;
        idle(15);
        check("postrst_valid", 32'(m_valid_a), 32'd0);
        beat(8'd5, 1'b0);
        beat(8'd6, 1'b1);
        wait_valid(lat);
        check("postrst_bcd",   32'(m_bcd_a),   32'h011);
        check("postrst_count", 32'(m_count_a), 32'd2);
        handshake();
        idle(2);

        run_cmp = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
